// File: rtl/accel_bridge_pkg.sv
// Shared constants for the Wishbone accelerator bridge:
// register offsets, CTRL/STATUS bit positions and the default window base.
package accel_bridge_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3200_0000;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_CMD_DATA = 8'h08;
    localparam logic [7:0] OFF_RES_DATA = 8'h0C;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int ST_CMD_FULL  = 0;
    localparam int ST_CMD_EMPTY = 1;
    localparam int ST_RES_FULL  = 2;
    localparam int ST_RES_EMPTY = 3;
    localparam int ST_CMD_CNT   = 4;
    localparam int ST_RES_CNT   = 8;
    localparam int ST_OVERFLOW  = 12;
    localparam int ST_UNDERFLOW = 13;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } ack_state_e;

    function automatic logic [31:0] pack_status(
        input logic       cmd_full,
        input logic       cmd_empty,
        input logic       res_full,
        input logic       res_empty,
        input logic [3:0] cmd_cnt,
        input logic [3:0] res_cnt,
        input logic       ovf,
        input logic       udf
    );
        logic [31:0] v;
        v                            = '0;
        v[ST_CMD_FULL]               = cmd_full;
        v[ST_CMD_EMPTY]              = cmd_empty;
        v[ST_RES_FULL]               = res_full;
        v[ST_RES_EMPTY]              = res_empty;
        v[ST_CMD_CNT +: 4]           = cmd_cnt;
        v[ST_RES_CNT +: 4]           = res_cnt;
        v[ST_OVERFLOW]               = ovf;
        v[ST_UNDERFLOW]              = udf;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; a pop frees a slot
// for a push in the same cycle, so a full FIFO can stream through.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign dout   = r_mem[r_rd];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_accel_bridge.sv
// Wishbone classic slave exposing a command FIFO and a result FIFO
// to an accelerator core, with a result-available interrupt.
module wb_accel_bridge
    import accel_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_data,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_data,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ack_state_e  r_state;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_en;
    logic        r_irq_en;
    logic        r_ovf;
    logic        r_udf;

    logic          w_hit;
    logic          w_access;
    logic [7:0]    w_off;
    logic          w_is_ctrl;
    logic          w_is_status;
    logic          w_is_cmd;
    logic          w_is_res;
    logic          w_wr_ctrl;
    logic          w_wr_status;
    logic          w_flush;
    logic          w_fifo_clr;
    logic          w_cmd_push;
    logic          w_cmd_pop;
    logic          w_cmd_full;
    logic          w_cmd_empty;
    logic [CW-1:0] w_cmd_count;
    logic          w_res_push;
    logic          w_res_rd;
    logic          w_res_full;
    logic          w_res_empty;
    logic [CW-1:0] w_res_count;
    logic [31:0]   w_res_dout;
    logic          w_ovf_set;
    logic          w_udf_set;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    assign w_hit    = wbs_cyc_i & wbs_stb_i
                    & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_access = (r_state == S_IDLE) & w_hit;
    assign w_off    = wbs_adr_i[7:0];

    assign w_is_ctrl   = (w_off == OFF_CTRL);
    assign w_is_status = (w_off == OFF_STATUS);
    assign w_is_cmd    = (w_off == OFF_CMD_DATA);
    assign w_is_res    = (w_off == OFF_RES_DATA);

    assign w_wr_ctrl   = w_access & wbs_we_i & w_is_ctrl;
    assign w_wr_status = w_access & wbs_we_i & w_is_status;
    assign w_flush     = w_wr_ctrl & wbs_dat_i[CTRL_FLUSH];
    assign w_fifo_clr  = wb_rst_i | w_flush;

    assign w_cmd_push = w_access & wbs_we_i & w_is_cmd
                      & (wbs_sel_i == 4'hF);
    assign w_cmd_pop  = cmd_valid & cmd_ready;
    assign w_res_rd   = w_access & ~wbs_we_i & w_is_res;
    assign w_res_push = res_valid & res_ready;

    // A full FIFO still accepts a push when the stream drains it this cycle.
    assign w_ovf_set = w_cmd_push & w_cmd_full & ~w_cmd_pop;
    assign w_udf_set = w_res_rd & w_res_empty;

    assign w_status = pack_status(
        w_cmd_full, w_cmd_empty, w_res_full, w_res_empty,
        4'(w_cmd_count), 4'(w_res_count), r_ovf, r_udf
    );

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_is_ctrl:   w_rdata = {30'b0, r_irq_en, r_en};
            w_is_status: w_rdata = w_status;
            w_is_res:    w_rdata = w_res_empty ? '0 : w_res_dout;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    r_dat <= '0;
                    if (w_hit) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_dat   <= wbs_we_i ? '0 : w_rdata;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_dat   <= '0;
                end
            endcase
            if (w_wr_ctrl) begin
                r_en     <= wbs_dat_i[CTRL_ENABLE];
                r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && wbs_dat_i[ST_OVERFLOW]) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (w_wr_status && wbs_dat_i[ST_UNDERFLOW]) begin
                r_udf <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (wb_clk_i),
        .clr   (w_fifo_clr),
        .push  (w_cmd_push),
        .pop   (w_cmd_pop),
        .din   (wbs_dat_i),
        .dout  (cmd_data),
        .full  (w_cmd_full),
        .empty (w_cmd_empty),
        .count (w_cmd_count)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (wb_clk_i),
        .clr   (w_fifo_clr),
        .push  (w_res_push),
        .pop   (w_res_rd),
        .din   (res_data),
        .dout  (w_res_dout),
        .full  (w_res_full),
        .empty (w_res_empty),
        .count (w_res_count)
    );

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign cmd_valid = r_en & ~w_cmd_empty;
    assign res_ready = r_en & ~w_res_full;
    assign irq       = r_irq_en & ~w_res_empty;

endmodule

// File: tb/tb_wb_accel_bridge.sv
// Self-checking bench for wb_accel_bridge: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_wb_accel_bridge;

    localparam logic [31:0] BASE  = 32'h3200_0000;
    localparam int          DEPTH = 8;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_CMD  = BASE + 32'h08;
    localparam logic [31:0] A_RES  = BASE + 32'h0C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_data;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [31:0] res_data = '0;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;
    bit rnd_stream = 0;

    logic [31:0] m_cmd[$];
    logic [31:0] m_res[$];
    logic [31:0] seen[$];
    bit          m_en, m_irqen, m_ovf, m_udf, m_busy;
    logic [31:0] m_dat;

    wb_accel_bridge #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int c;
        int r;
        logic [31:0] v;
        c = m_cmd.size();
        r = m_res.size();
        v = '0;
        v[0] = (c == DEPTH);
        v[1] = (c == 0);
        v[2] = (r == DEPTH);
        v[3] = (r == 0);
        v[7:4] = 4'(c);
        v[11:8] = 4'(r);
        v[12] = m_ovf;
        v[13] = m_udf;
        return v;
    endfunction

    task automatic m_reset();
        m_cmd.delete();
        m_res.delete();
        m_en = 0; m_irqen = 0; m_ovf = 0; m_udf = 0;
        m_busy = 0; m_dat = '0;
    endtask

    // One clock: check stream outputs, advance the model, then check ack/data.
    task automatic cycle();
        bit          pop_c, push_r, hit, flush, cpush, rpop;
        logic [31:0] rv;
        logic [7:0]  off;
        int          csz;
        if (rnd_stream) begin
            cmd_ready = 1'($urandom_range(0, 1));
            res_valid = 1'($urandom_range(0, 1));
            res_data  = $urandom;
        end
        chk("cmd_valid", 32'(cmd_valid), 32'(m_en && m_cmd.size() > 0));
        if (m_en && m_cmd.size() > 0) chk("cmd_data", cmd_data, m_cmd[0]);
        chk("res_ready", 32'(res_ready), 32'(m_en && m_res.size() < DEPTH));
        chk("irq", 32'(irq), 32'(m_irqen && m_res.size() > 0));
        if (cmd_valid && cmd_ready) seen.push_back(cmd_data);
        if (rst) begin
            m_reset();
        end else begin
            pop_c  = m_en && m_cmd.size() > 0 && cmd_ready;
            push_r = m_en && m_res.size() < DEPTH && res_valid;
            hit    = cyc && stb && (adr[31:8] == BASE[31:8]);
            flush = 0; cpush = 0; rpop = 0; rv = '0;
            m_dat = '0;
            if (m_busy) begin
                m_busy = 0;
            end else if (hit) begin
                m_busy = 1;
                off = adr[7:0];
                if (we) begin
                    if (off == 8'h00) begin
                        m_en = wdat[0]; m_irqen = wdat[1]; flush = wdat[2];
                    end else if (off == 8'h04) begin
                        if (wdat[12]) m_ovf = 0;
                        if (wdat[13]) m_udf = 0;
                    end else if (off == 8'h08 && sel == 4'hF) begin
                        cpush = 1;
                    end
                end else begin
                    if (off == 8'h00) rv = {30'b0, m_irqen, m_en};
                    else if (off == 8'h04) rv = m_status();
                    else if (off == 8'h0C) begin
                        rpop = 1;
                        rv = (m_res.size() > 0) ? m_res[0] : '0;
                    end
                    m_dat = rv;
                end
            end
            if (flush) begin
                m_cmd.delete();
                m_res.delete();
            end else begin
                csz = m_cmd.size();
                if (pop_c) void'(m_cmd.pop_front());
                if (cpush) begin
                    if (csz < DEPTH || pop_c) m_cmd.push_back(wdat);
                    else m_ovf = 1;
                end
                if (rpop) begin
                    if (m_res.size() > 0) void'(m_res.pop_front());
                    else m_udf = 1;
                end
                if (push_r) m_res.push_back(res_data);
            end
        end
        @(posedge clk);
        #1;
        chk("ack", 32'(ack), 32'(m_busy));
        chk("dat_o", rdat, m_busy ? m_dat : 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wb_acc(input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        cycle();
        rd = rdat;
        cycle();
        cyc = 0; stb = 0; we = 0; sel = 4'hF;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_acc(1, a, d, 4'hF, dummy);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] rd);
        wb_acc(0, a, 32'h0, 4'hF, rd);
    endtask

    initial begin
        logic [31:0] rd;
        int          op;
        logic [31:0] d;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        cycle();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        rst = 0;
        wb_rd(A_STAT, rd);
        chk("rst_status", rd, 32'h0000_000A);

        // In-order command streaming.
        cmd_ready = 1;
        wb_wr(A_CTRL, 32'h1);
        seen.delete();
        wb_wr(A_CMD, 32'hA1);
        wb_wr(A_CMD, 32'hA2);
        wb_wr(A_CMD, 32'hA3);
        idle(2);
        chk("stream_n", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("stream0", seen[0], 32'hA1);
            chk("stream1", seen[1], 32'hA2);
            chk("stream2", seen[2], 32'hA3);
        end

        // Overflow on the ninth push.
        cmd_ready = 0;
        for (int i = 0; i < 9; i++) wb_wr(A_CMD, 32'h100 + 32'(i));
        wb_rd(A_STAT, rd);
        chk("ovf_status", rd, 32'h0000_1089);
        wb_wr(A_STAT, 32'h1000);
        wb_rd(A_STAT, rd);
        chk("ovf_cleared", rd, 32'h0000_0089);

        // Push and pop together while full.
        seen.delete();
        cyc = 1; stb = 1; we = 1; adr = A_CMD; wdat = 32'h200; sel = 4'hF;
        cmd_ready = 1;
        cycle();
        cmd_ready = 0;
        cycle();
        cyc = 0; stb = 0; we = 0;
        wb_rd(A_STAT, rd);
        chk("full_pp_status", rd, 32'h0000_0089);
        cmd_ready = 1;
        idle(10);
        cmd_ready = 0;
        chk("drain_n", 32'(seen.size()), 32'd9);
        if (seen.size() == 9) begin
            for (int i = 0; i < 8; i++) chk("drain_ord", seen[i], 32'h100 + 32'(i));
            chk("drain_last", seen[8], 32'h200);
        end

        // Results, interrupt and underflow.
        wb_wr(A_CTRL, 32'h3);
        res_valid = 1; res_data = 32'h5;
        cycle();
        res_data = 32'h6;
        cycle();
        res_valid = 0;
        chk("irq_up", 32'(irq), 32'h1);
        wb_rd(A_RES, rd);
        chk("res_5", rd, 32'h5);
        wb_rd(A_RES, rd);
        chk("res_6", rd, 32'h6);
        chk("irq_down", 32'(irq), 32'h0);
        wb_rd(A_RES, rd);
        chk("res_empty_rd", rd, 32'h0);
        wb_rd(A_STAT, rd);
        chk("udf_status", rd, 32'h0000_200A);

        // Flush with both FIFOs holding four entries.
        for (int i = 0; i < 4; i++) wb_wr(A_CMD, 32'h300 + 32'(i));
        res_valid = 1;
        for (int i = 0; i < 4; i++) begin
            res_data = 32'h400 + 32'(i);
            cycle();
        end
        res_valid = 0;
        wb_rd(A_STAT, rd);
        chk("pre_flush", rd, 32'h0000_2440);
        wb_wr(A_CTRL, 32'h5);
        chk("flush_cmd_valid", 32'(cmd_valid), 32'h0);
        wb_rd(A_STAT, rd);
        chk("post_flush", rd, 32'h0000_200A);
        wb_rd(A_CTRL, rd);
        chk("ctrl_after_flush", rd, 32'h1);
        wb_wr(A_STAT, 32'h2000);

        // Randomized traffic.
        rnd_stream = 1;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 11);
            case (op)
                0: begin
                    d = '0;
                    d[0] = ($urandom_range(0, 3) != 0);
                    d[1] = 1'($urandom_range(0, 1));
                    d[2] = ($urandom_range(0, 7) == 0);
                    wb_wr(A_CTRL, d);
                end
                1: wb_rd(A_STAT, rd);
                2: wb_wr(A_STAT, $urandom);
                3, 4, 5: wb_wr(A_CMD, $urandom);
                6: wb_acc(1, A_CMD, $urandom, 4'($urandom_range(0, 14)), rd);
                7, 8: wb_rd(A_RES, rd);
                9: wb_acc(1'($urandom_range(0, 1)),
                          BASE + 32'(4 * $urandom_range(4, 63)), $urandom, 4'hF, rd);
                10: begin
                    wb_rd(A_CMD, rd);
                    wb_wr(A_RES, $urandom);
                    wb_rd(A_CTRL, rd);
                end
                default: begin
                    wb_acc(0, 32'h3300_0000 | 32'($urandom_range(0, 255)), 0, 4'hF, rd);
                    idle($urandom_range(0, 3));
                end
            endcase
        end
        rnd_stream = 0;
        cmd_ready = 0;
        res_valid = 0;

        // Miss is never acked.
        cyc = 1; stb = 1; we = 0; adr = 32'h3300_0000;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("miss_noack", 32'(ack), 32'h0);
        end
        cyc = 0; stb = 0;

        // Reset asserted mid-ACK.
        wb_wr(A_CTRL, 32'h3);
        wb_wr(A_CMD, 32'h77);
        res_valid = 1; res_data = 32'h88;
        cycle();
        res_valid = 0;
        cyc = 1; stb = 1; we = 0; adr = A_STAT;
        cycle();
        chk("pre_rst_ack", 32'(ack), 32'h1);
        rst = 1;
        cycle();
        rst = 0;
        cyc = 0; stb = 0;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_dat", rdat, 32'h0);
        chk("mid_rst_cmdv", 32'(cmd_valid), 32'h0);
        chk("mid_rst_resr", 32'(res_ready), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        idle(2);
        wb_rd(A_STAT, rd);
        chk("post_rst_status", rd, 32'h0000_000A);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
